// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage: owns the program counter and the IF/ID pipeline
// register. The PC advances by 4 each cycle unless held by a stall or
// redirected by a jump decoded in ID or a taken branch/JR resolved in EX.
// Redirects insert a bubble into IF/ID so the wrong-path fetch is discarded.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   CNT_W        width of the saturating redirect counter
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   stall        hazard-unit stall: PC and IF/ID hold
//   jump         J/JAL decoded in ID (ignored while stalled)
//   jump_target  composed jump address
//   ex_redirect  taken branch / JR resolved in EX (overrides stall)
//   ex_target    EX redirect address
//   imem_rdata   instruction word read combinationally at imem_addr
//   imem_addr    current PC (registered, no input-to-output path)
//   pc4_hi       ifid_pc4[31:28], for the jump-target composer
//   ifid_pc4     PC+4 of the instruction in ID
//   ifid_instr   instruction in ID (0 for a bubble)
//   ifid_valid   1 when ifid_instr is a real instruction
//   misalign_err sticky: some redirect target had nonzero bits [1:0]
//   redirect_cnt saturating count of accepted redirects
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             ex_redirect,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [3:0]       pc4_hi,
    output logic [31:0]      ifid_pc4,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    // Source of the next PC, in priority order EX > JUMP > HOLD > SEQ.
    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_JUMP,
        SRC_EX
    } pc_src_t;

    pc_src_t          pc_src;
    logic [31:0]      pc_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      raw_target;
    logic             redirect;

    logic [31:0]      pc_d;
    logic [31:0]      ifid_pc4_d;
    logic [31:0]      ifid_instr_d;
    logic             ifid_valid_d;
    logic             misalign_d;
    logic [CNT_W-1:0] cnt_d;

    assign imem_addr = pc_q;
    assign pc4_hi    = ifid_pc4[31:28];
    assign pc_plus4  = pc_q + 32'd4;

    always_comb begin
        pc_src = SRC_SEQ;
        if (ex_redirect)
            pc_src = SRC_EX;
        else if (jump && !stall)
            pc_src = SRC_JUMP;
        else if (stall)
            pc_src = SRC_HOLD;
    end

    assign redirect   = (pc_src == SRC_EX) || (pc_src == SRC_JUMP);
    assign raw_target = (pc_src == SRC_EX) ? ex_target : jump_target;

    always_comb begin
        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4;
        ifid_instr_d = ifid_instr;
        ifid_valid_d = ifid_valid;
        misalign_d   = misalign_err;
        cnt_d        = redirect_cnt;

        unique case (pc_src)
            SRC_EX, SRC_JUMP: begin
                // Word-align the target; the low bits only feed the sticky error.
                pc_d         = {raw_target[31:2], 2'b00};
                ifid_instr_d = '0;
                ifid_valid_d = 1'b0;
                if (raw_target[1:0] != 2'b00)
                    misalign_d = 1'b1;
            end
            SRC_HOLD: begin
                // everything holds at its default
            end
            SRC_SEQ: begin
                pc_d         = pc_plus4;
                ifid_pc4_d   = pc_plus4;
                ifid_instr_d = imem_rdata;
                ifid_valid_d = 1'b1;
            end
            default: begin
            end
        endcase

        if (redirect && !(&redirect_cnt))
            cnt_d = redirect_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_pc4     <= RESET_PC;
            ifid_instr   <= '0;
            ifid_valid   <= 1'b0;
            misalign_err <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc4     <= ifid_pc4_d;
            ifid_instr   <= ifid_instr_d;
            ifid_valid   <= ifid_valid_d;
            misalign_err <= misalign_d;
            redirect_cnt <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed and randomized bench for pc_fetch_unit. A behavioural model tracks
// the architectural fetch state cycle by cycle from the next-PC rules; every
// DUT output is compared against it 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned CW     = 4;   // narrow counter so saturation is reachable

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          jump;
    logic [31:0]   jump_target;
    logic          ex_redirect;
    logic [31:0]   ex_target;
    logic [31:0]   imem_rdata;
    logic [31:0]   imem_addr;
    logic [3:0]    pc4_hi;
    logic [31:0]   ifid_pc4;
    logic [31:0]   ifid_instr;
    logic          ifid_valid;
    logic          misalign_err;
    logic [CW-1:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid, m_err;
    int          m_cnt;

    pc_fetch_unit #(
        .RESET_PC (RST_PC),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .imem_rdata   (imem_rdata),
        .imem_addr    (imem_addr),
        .pc4_hi       (pc4_hi),
        .ifid_pc4     (ifid_pc4),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word is tagged with its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"},  imem_addr,              m_pc);
        check({tag, ".ifid_pc4"},   ifid_pc4,               m_pc4);
        check({tag, ".pc4_hi"},     {28'h0, pc4_hi},        {28'h0, m_pc4[31:28]});
        check({tag, ".ifid_instr"}, ifid_instr,             m_instr);
        check({tag, ".ifid_valid"}, {31'h0, ifid_valid},    {31'h0, m_valid});
        check({tag, ".misalign"},   {31'h0, misalign_err},  {31'h0, m_err});
        check({tag, ".cnt"},        32'(redirect_cnt),      32'(m_cnt));
    endtask

    // One clock: advance the model from the inputs present at the edge,
    // then compare everything shortly after the edge.
    task automatic step(input string tag);
        logic [31:0] tgt;
        bit          take;
        @(posedge clk);
        take = 1'b0;
        tgt  = '0;
        if (!rst_n) begin
            m_pc = RST_PC; m_pc4 = RST_PC; m_instr = '0;
            m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else if (ex_redirect) begin
            take = 1'b1; tgt = ex_target;
        end else if (jump && !stall) begin
            take = 1'b1; tgt = jump_target;
        end else if (!stall) begin
            m_instr = mem_word(m_pc);
            m_pc    = m_pc + 32'd4;
            m_pc4   = m_pc;
            m_valid = 1'b1;
        end
        if (take) begin
            if (tgt % 4 != 0) m_err = 1'b1;
            m_pc    = tgt - (tgt % 4);
            m_instr = '0;
            m_valid = 1'b0;
            if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; jump = 1'b0; ex_redirect = 1'b0;
        jump_target = '0; ex_target = '0;
    endtask

    initial begin
        m_pc = 'x; m_pc4 = 'x; m_instr = 'x; m_valid = 1'bx; m_err = 1'bx; m_cnt = 0;
        idle_inputs();
        rst_n = 1'b0;
        #2;

        // Reset, with every other control active to show it is overridden
        stall = 1'b1; jump = 1'b1; ex_redirect = 1'b1;
        jump_target = 32'h1234_5678; ex_target = 32'h0000_0102;
        step("reset0");
        step("reset1");
        check("reset.addr_const", imem_addr, 32'h0000_3000);
        check("reset.cnt_const",  32'(redirect_cnt), 32'd0);
        idle_inputs();

        // Sequential fetch after reset release
        rst_n = 1'b1;
        step("seq1");
        check("seq1.valid_const", {31'h0, ifid_valid}, 32'd1);
        check("seq1.pc4_const",   ifid_pc4, 32'h0000_3004);
        check("seq1.instr_const", ifid_instr, 32'h0000_3000 ^ 32'hA5A5_5A5A);
        step("seq2");
        check("seq2.addr_const", imem_addr, 32'h0000_3008);

        // Jump from PC 0x3008
        jump = 1'b1; jump_target = 32'h0040_0010;
        step("jump");
        check("jump.addr_const", imem_addr, 32'h0040_0010);
        check("jump.cnt_const",  32'(redirect_cnt), 32'd1);
        idle_inputs();
        step("jump_after");

        // Get to 0x300C, then stall with a pending jump
        ex_redirect = 1'b1; ex_target = 32'h0000_300C;
        step("ex_to_300c");
        idle_inputs();
        stall = 1'b1; jump = 1'b1; jump_target = 32'h0050_0020;
        step("stall_j1");
        step("stall_j2");
        step("stall_j3");
        check("stall.addr_const", imem_addr, 32'h0000_300C);
        stall = 1'b0;
        step("stall_release_jump");
        check("stall.jump_taken", imem_addr, 32'h0050_0020);
        idle_inputs();

        // EX redirect beats stall and jump; counted once
        stall = 1'b1; jump = 1'b1; jump_target = 32'h0060_0000;
        ex_redirect = 1'b1; ex_target = 32'h0000_3100;
        step("ex_prio");
        check("ex_prio.addr_const", imem_addr, 32'h0000_3100);
        idle_inputs();

        // Misaligned EX target, error sticks through later redirects
        ex_redirect = 1'b1; ex_target = 32'h0000_3102;
        step("misalign");
        check("misalign.addr_const", imem_addr, 32'h0000_3100);
        check("misalign.err_const",  {31'h0, misalign_err}, 32'd1);
        idle_inputs();
        jump = 1'b1; jump_target = 32'h0000_3200;
        step("misalign_sticky_j");
        idle_inputs();
        step("misalign_sticky_seq");

        // Randomized traffic; counter saturates along the way
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            jump        = ($urandom_range(0, 4) == 0);
            ex_redirect = ($urandom_range(0, 6) == 0);
            jump_target = $urandom;
            ex_target   = $urandom;
            if ($urandom_range(0, 7) != 0) jump_target[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) ex_target[1:0]   = 2'b00;
            step("rand");
        end
        idle_inputs();
        rst_n = 1'b1;

        // Wrap at the top of the address space, then reset mid-stall
        ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFC;
        step("to_top");
        idle_inputs();
        step("wrap");
        check("wrap.addr_const", imem_addr, 32'h0000_0000);
        check("wrap.pc4_const",  ifid_pc4,  32'h0000_0000);
        stall = 1'b1;
        step("wrap_stall");
        jump = 1'b1; jump_target = 32'h0000_0101;
        ex_redirect = 1'b1; ex_target = 32'h0000_0203;
        rst_n = 1'b0;
        step("reset_mid_stall");
        check("rst2.addr_const", imem_addr, 32'h0000_3000);
        check("rst2.err_const",  {31'h0, misalign_err}, 32'd0);
        idle_inputs();
        rst_n = 1'b1;
        step("post_reset_fetch");
        check("post_reset.valid_const", {31'h0, ifid_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
